// File: rtl/wb_slave_ram.sv
// Wishbone classic-cycle slave backed by a word-addressed RAM with byte lanes and wait states.
// Define WB_SLAVE_RAM_ERR_EN to answer out-of-range requests with wbs_err_o instead of aliasing.
module wb_slave_ram #(
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int          DEPTH_WORDS = 1024,
   parameter int          WAIT_STATES = 1
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_n_i,
   input  logic [31:0] wbs_adr_i,
   input  logic [31:0] wbs_dat_i,
   output logic [31:0] wbs_dat_o,
   input  logic        wbs_we_i,
   input  logic [3:0]  wbs_sel_i,
   input  logic        wbs_stb_i,
   input  logic        wbs_cyc_i,
   output logic        wbs_ack_o,
   output logic        wbs_err_o
);

   localparam int          AddrW     = $clog2(DEPTH_WORDS);
   localparam logic [31:0] SpanBytes = 32'(4 * DEPTH_WORDS);
   localparam logic [3:0]  WaitLoad  = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} StateT;

   StateT             state_q, state_d;
   logic [3:0]        waitCnt_q, waitCnt_d;
   logic              ack_q;
   logic [31:0]       rdata_q;
   logic [31:0]       mem [DEPTH_WORDS];

   logic              request;
   logic              enterResp;
   logic              respErr;
   logic              inRange;
   logic              doWrite;
   logic              doRead;
   logic [31:0]       offset;
   logic [AddrW-1:0]  index;
   logic              unusedDecode;

   assign request      = wbs_cyc_i & wbs_stb_i;
   assign offset       = wbs_adr_i - BASE_ADDR;
   assign index        = offset[AddrW+1:2];
   assign inRange      = offset < SpanBytes;
   assign unusedDecode = ^{offset[1:0], inRange};

`ifdef WB_SLAVE_RAM_ERR_EN
   logic err_q;

   assign respErr = ~inRange;

   // Error response is registered exactly like ack so neither has a combinational input path.
   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         err_q <= 1'b0;
      end else begin
         err_q <= enterResp & respErr;
      end
   end

   assign wbs_err_o = err_q;
`else
   assign respErr   = 1'b0;
   assign wbs_err_o = 1'b0;
`endif

   assign doWrite = enterResp & wbs_we_i & ~respErr;
   assign doRead  = enterResp & ~wbs_we_i & ~respErr;

   // Next-state logic; enterResp marks the single edge on which the transfer takes effect.
   always_comb begin
      state_d   = state_q;
      waitCnt_d = waitCnt_q;
      enterResp = 1'b0;
      case (state_q)
         IDLE: begin
            if (request) begin
               if (WAIT_STATES == 0) begin
                  state_d   = RESP;
                  enterResp = 1'b1;
               end else begin
                  state_d   = WAIT;
                  waitCnt_d = WaitLoad;
               end
            end
         end
         WAIT: begin
            if (!request) begin
               state_d   = IDLE;
               waitCnt_d = 4'd0;
            end else if (waitCnt_q == 4'd0) begin
               state_d   = RESP;
               enterResp = 1'b1;
            end else begin
               waitCnt_d = waitCnt_q - 4'd1;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d   = IDLE;
            waitCnt_d = 4'd0;
         end
      endcase
   end

   // Control state and bus outputs; read data is only replaced by a successful read.
   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         state_q   <= IDLE;
         waitCnt_q <= 4'd0;
         ack_q     <= 1'b0;
         rdata_q   <= 32'h0;
      end else begin
         state_q   <= state_d;
         waitCnt_q <= waitCnt_d;
         ack_q     <= enterResp & ~respErr;
         if (doRead) begin
            rdata_q <= mem[index];
         end
      end
   end

   // The array itself is never reset, so contents survive a reset pulse.
   always_ff @(posedge wb_clk_i) begin
      if (doWrite) begin
         for (int b = 0; b < 4; b++) begin
            if (wbs_sel_i[b]) begin
               mem[index][8*b +: 8] <= wbs_dat_i[8*b +: 8];
            end
         end
      end
   end

   assign wbs_ack_o = ack_q;
   assign wbs_dat_o = rdata_q;

endmodule

// File: tb/tb_wb_slave_ram.sv
// Directed bench for wb_slave_ram: three instances cover one, three and zero wait states.
// Instance 0 has a non-zero base address so the offset subtraction is exercised.
module tb_wb_slave_ram;

   localparam logic [31:0] Base0 = 32'h8000_0000;
`ifdef WB_SLAVE_RAM_ERR_EN
   localparam logic ErrEn = 1'b1;
`else
   localparam logic ErrEn = 1'b0;
`endif

   logic        clk;
   logic        rstN;
   logic [31:0] adrI [3];
   logic [31:0] datI [3];
   logic [31:0] datO [3];
   logic        weI  [3];
   logic [3:0]  selI [3];
   logic        stbI [3];
   logic        cycI [3];
   logic        ack  [3];
   logic        err  [3];

   int          nChecks = 0;
   int          nFails  = 0;

   typedef struct {
      logic        we;
      logic [31:0] off;
      logic [31:0] dat;
      logic [3:0]  sel;
      logic [31:0] expDat;
      logic        expErr;
   } VecT;

   VecT vecs [12];

   wb_slave_ram #(.BASE_ADDR(Base0), .DEPTH_WORDS(1024), .WAIT_STATES(1)) dut0 (
      .wb_clk_i(clk), .wb_rst_n_i(rstN), .wbs_adr_i(adrI[0]), .wbs_dat_i(datI[0]),
      .wbs_dat_o(datO[0]), .wbs_we_i(weI[0]), .wbs_sel_i(selI[0]), .wbs_stb_i(stbI[0]),
      .wbs_cyc_i(cycI[0]), .wbs_ack_o(ack[0]), .wbs_err_o(err[0]));

   wb_slave_ram #(.BASE_ADDR(32'h0), .DEPTH_WORDS(1024), .WAIT_STATES(3)) dut1 (
      .wb_clk_i(clk), .wb_rst_n_i(rstN), .wbs_adr_i(adrI[1]), .wbs_dat_i(datI[1]),
      .wbs_dat_o(datO[1]), .wbs_we_i(weI[1]), .wbs_sel_i(selI[1]), .wbs_stb_i(stbI[1]),
      .wbs_cyc_i(cycI[1]), .wbs_ack_o(ack[1]), .wbs_err_o(err[1]));

   wb_slave_ram #(.BASE_ADDR(32'h0), .DEPTH_WORDS(1024), .WAIT_STATES(0)) dut2 (
      .wb_clk_i(clk), .wb_rst_n_i(rstN), .wbs_adr_i(adrI[2]), .wbs_dat_i(datI[2]),
      .wbs_dat_o(datO[2]), .wbs_we_i(weI[2]), .wbs_sel_i(selI[2]), .wbs_stb_i(stbI[2]),
      .wbs_cyc_i(cycI[2]), .wbs_ack_o(ack[2]), .wbs_err_o(err[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case a handshake never completes outside a bounded wait.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      nChecks++;
      if (actual !== expected) begin
         nFails++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input int k, input logic we, input logic [31:0] adr,
                                input logic [31:0] dat, input logic [3:0] sel);
      adrI[k] = adr;
      datI[k] = dat;
      weI[k]  = we;
      selI[k] = sel;
      cycI[k] = 1'b1;
      stbI[k] = 1'b1;
   endtask

   // Waits for ack or err, recording the cycle it was seen in, then ends the bus cycle.
   task automatic waitResponse(input int k, output int lat, output logic gotErr, output logic [31:0] rdata);
      lat    = -1;
      gotErr = 1'b0;
      rdata  = 32'h0;
      for (int n = 1; n <= 20; n++) begin
         @(posedge clk);
         @(negedge clk);
         if (ack[k] || err[k]) begin
            lat    = n;
            gotErr = err[k];
            rdata  = datO[k];
            break;
         end
      end
      cycI[k] = 1'b0;
      stbI[k] = 1'b0;
   endtask

   initial begin
      int          lat;
      logic        gotErr;
      logic [31:0] rdata;
      logic [31:0] lastRead;
      logic [31:0] expD;
      logic [31:0] b2bData [3];

      vecs[0]  = '{1'b1, 32'h10,   32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0};
      vecs[1]  = '{1'b0, 32'h10,   32'h0,         4'hF, 32'hDEAD_BEEF, 1'b0};
      vecs[2]  = '{1'b1, 32'h20,   32'h1122_3344, 4'hF, 32'h0, 1'b0};
      vecs[3]  = '{1'b1, 32'h20,   32'hAABB_CCDD, 4'b0101, 32'h0, 1'b0};
      vecs[4]  = '{1'b0, 32'h20,   32'h0,         4'h0, 32'h11BB_33DD, 1'b0};
      vecs[5]  = '{1'b1, 32'h20,   32'hFFFF_FFFF, 4'b0000, 32'h0, 1'b0};
      vecs[6]  = '{1'b0, 32'h20,   32'h0,         4'h3, 32'h11BB_33DD, 1'b0};
      vecs[7]  = '{1'b1, 32'h0,    32'h1234_5678, 4'hF, 32'h0, 1'b0};
      vecs[8]  = '{1'b1, 32'hFFC,  32'h0A0B_0C0D, 4'hF, 32'h0, 1'b0};
      vecs[9]  = '{1'b0, 32'hFFC,  32'h0,         4'hF, 32'h0A0B_0C0D, 1'b0};
      vecs[10] = '{1'b1, 32'h1000, 32'h55AA_55AA, 4'hF, 32'h0, ErrEn};
      vecs[11] = '{1'b0, 32'h0,    32'h0,         4'hF,
                   ErrEn ? 32'h1234_5678 : 32'h55AA_55AA, 1'b0};

      for (int k = 0; k < 3; k++) begin
         adrI[k] = 32'h0;
         datI[k] = 32'h0;
         weI[k]  = 1'b0;
         selI[k] = 4'h0;
         cycI[k] = 1'b0;
         stbI[k] = 1'b0;
      end

      // Reset held for three cycles with a write already strobed on instance 0.
      rstN = 1'b0;
      @(negedge clk);
      applyStimulus(0, vecs[0].we, Base0 + vecs[0].off, vecs[0].dat, vecs[0].sel);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checkOutput("reset ack", 32'(ack[0]), 32'h0);
         checkOutput("reset err", 32'(err[0]), 32'h0);
         checkOutput("reset dat_o", datO[0], 32'h0);
      end
      rstN = 1'b1;

      // Table-driven transfers on the single-wait-state instance.
      lastRead = 32'h0;
      for (int i = 0; i < 12; i++) begin
         applyStimulus(0, vecs[i].we, Base0 + vecs[i].off, vecs[i].dat, vecs[i].sel);
         waitResponse(0, lat, gotErr, rdata);
         checkOutput($sformatf("vec%0d latency", i), 32'(lat), 32'd2);
         checkOutput($sformatf("vec%0d err", i), 32'(gotErr), 32'(vecs[i].expErr));
         expD = (vecs[i].we || vecs[i].expErr) ? lastRead : vecs[i].expDat;
         checkOutput($sformatf("vec%0d dat_o", i), rdata, expD);
         if (!vecs[i].we && !vecs[i].expErr) lastRead = vecs[i].expDat;
         @(posedge clk);
         @(negedge clk);
         checkOutput($sformatf("vec%0d ack width", i), 32'(ack[0]), 32'h0);
         checkOutput($sformatf("vec%0d err width", i), 32'(err[0]), 32'h0);
      end

      // Three wait states: seed a word, then abort a write to it by dropping stb in cycle 2.
      applyStimulus(1, 1'b1, 32'h44, 32'h1111_1111, 4'hF);
      waitResponse(1, lat, gotErr, rdata);
      checkOutput("ws3 seed latency", 32'(lat), 32'd4);
      applyStimulus(1, 1'b1, 32'h44, 32'h2222_2222, 4'hF);
      @(posedge clk);
      @(negedge clk);
      checkOutput("abort cycle1 ack", 32'(ack[1]), 32'h0);
      @(posedge clk);
      @(negedge clk);
      checkOutput("abort cycle2 ack", 32'(ack[1]), 32'h0);
      stbI[1] = 1'b0;
      for (int c = 3; c < 7; c++) begin
         @(posedge clk);
         @(negedge clk);
         checkOutput($sformatf("abort cycle%0d ack", c), 32'(ack[1]), 32'h0);
      end
      cycI[1] = 1'b0;
      applyStimulus(1, 1'b0, 32'h44, 32'h0, 4'h0);
      waitResponse(1, lat, gotErr, rdata);
      checkOutput("post-abort latency", 32'(lat), 32'd4);
      checkOutput("post-abort data", rdata, 32'h1111_1111);

      // Zero wait states, cyc/stb held: write/read pairs must ack every second cycle.
      for (int j = 0; j < 3; j++) b2bData[j] = 32'hA500_0000 + 32'(j * 32'h0101);
      applyStimulus(2, 1'b1, 32'h0, b2bData[0], 4'hF);
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         @(negedge clk);
         checkOutput($sformatf("b2b%0d ack", i), 32'(ack[2]), 32'h1);
         if (i % 2 == 1) checkOutput($sformatf("b2b%0d data", i), datO[2], b2bData[i/2]);
         if (i < 5) begin
            applyStimulus(2, (i % 2 == 1), 32'(4 * ((i + 1) / 2)), b2bData[(i + 1) / 2], 4'hF);
         end else begin
            cycI[2] = 1'b0;
            stbI[2] = 1'b0;
         end
         @(posedge clk);
         @(negedge clk);
         checkOutput($sformatf("b2b%0d gap", i), 32'(ack[2]), 32'h0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
